itof_seq_unit: RTL and testbench
================================

# itof_seq_unit

Multi-cycle signed-integer to IEEE-754 single-precision converter (CVT.S.W). It performs the reverse of the FP ALU's ROUND/float-to-integer path and sits beside the FP ALU in the execute stage. It is driven by a start/done handshake from the pipeline control. Normalisation is iterative, one bit per cycle, to keep area small; rounding and flag generation take one further cycle.

## Interface
- No parameters; widths fixed at 32.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a conversion; sampled only when the block can accept (IDLE or DONE).
- `int_in`  in  32  two's-complement operand, captured on the accepting edge.
- `busy`  out  1  high in NORM and ROUND states.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `result`  out  32  IEEE single result; held until the next accepted start.
- `inexact`  out  1  conversion lost precision; held with `result`.
- `z_flag`  out  1  `result == 0`; held with `result`.

## Operation
- States: IDLE, NORM, ROUND, DONE.
- Accept (state IDLE or DONE, `start`=1):
  - capture `sign = int_in[31]`;
  - capture `mag` (32-bit unsigned) = |int_in|; -2^31 gives mag=0x80000000, which must not overflow;
  - set `exp` (8-bit) = 158.
  - If mag=0, go to DONE with result=0x00000000 and inexact=0. Otherwise go to NORM.
- NORM: if `mag[31]`=1, go to ROUND. Else shift `mag` left by 1, decrement `exp`, and stay in NORM.
- ROUND:
  - `mant = mag[30:8]`, `guard = mag[7]`, `sticky = |mag[6:0]`.
  - Round-to-nearest-even: increment when `guard & (sticky | mant[0])`.
  - If the increment carries out of `mant`, set `mant=0` and `exp=exp+1`. Exp never exceeds 158, so no infinity or NaN is possible.
  - `inexact = guard | sticky`.
  - Register `result = {sign, exp, mant}`, then go to DONE.
- DONE:
  - `done`=1 for this cycle.
  - Accept a new `start` here; otherwise go to IDLE.
- `start` in NORM or ROUND is ignored; no queueing.
- `result`, `inexact` and `z_flag` change only on entry to DONE.

## Timing
- Reset: state=IDLE; busy=0, done=0, result=0x00000000, inexact=0, z_flag=1.
- `rst` mid-conversion aborts to IDLE with the reset values above on the next edge. The conversion in flight is lost and produces no `done`.
- `rst` has priority over `start` on the same edge.
- Let start be accepted on edge T, and let k be the bit index of the leading one of `mag`.
  - NORM occupies T+1 through T+1+(31-k).
  - ROUND occurs at T+2+(31-k).
  - `done` is high at cycle T+3+(31-k).
  - Zero operand: `done` at T+1.
- Latency: minimum 3 cycles (k=31), maximum 34 cycles (int_in=±1). The zero case takes 1 cycle.
- Back-to-back: `start` asserted during the DONE cycle is accepted, so the next NORM begins at the following cycle with no IDLE bubble.

## Configuration
- `ITOF_RNE_EN` defined: ROUND applies round-to-nearest-even as specified above.
- `ITOF_RNE_EN` undefined: ROUND truncates toward zero (never increments `mant`). `inexact` is still `guard | sticky`. Latency is unchanged.

## Test plan
- int_in=1 → result=0x3F800000, inexact=0, z_flag=0, done at T+34.
- int_in=0x80000000 (-2^31) → result=0xCF000000, inexact=0, done at T+3.
- int_in=0x7FFFFFFF:
  - with `ITOF_RNE_EN` → result=0x4F000000 (carry into exponent), inexact=1, done at T+4;
  - without `ITOF_RNE_EN` → result=0x4EFFFFFF, inexact=1.
- int_in=0x01000001 (tie case, even mantissa) → result=0x4B800000, inexact=1, done at T+10.
- int_in=0 → result=0x00000000, z_flag=1, done at T+1. Then start with int_in=0xFFFFFFFF in the DONE cycle → result=0xBF800000, done 34 cycles later.
- Start int_in=1, assert `rst` at T+5 → IDLE with reset outputs, no `done` pulse. Start asserted during busy → ignored, and the first result is unchanged.

Source files
------------

// File: rtl/itof_seq_unit_if.sv
// ============================================================================
// itof_seq_unit_if
// ----------------------------------------------------------------------------
// Start/done handshake bundle for the integer-to-float converter.
//
// Signals:
//   start   - request a conversion (driven by pipeline control)
//   int_in  - 32-bit two's-complement operand
//   busy    - converter is normalising or rounding
//   done    - one-cycle pulse, result valid from this cycle
//   result  - IEEE-754 single-precision result, held until the next start
//   inexact - conversion lost precision, held with result
//   z_flag  - result is zero, held with result
//
// Modports:
//   master - pipeline control side (drives start/int_in)
//   slave  - converter side (drives status and result)
// ============================================================================
interface itof_seq_unit_if;
    logic        start;
    logic [31:0] int_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        inexact;
    logic        z_flag;

    modport master (
        output start,
        output int_in,
        input  busy,
        input  done,
        input  result,
        input  inexact,
        input  z_flag
    );

    modport slave (
        input  start,
        input  int_in,
        output busy,
        output done,
        output result,
        output inexact,
        output z_flag
    );
endinterface

// File: rtl/itof_seq_unit.sv
// ============================================================================
// itof_seq_unit
// ----------------------------------------------------------------------------
// Multi-cycle signed-integer to IEEE-754 single-precision converter (CVT.S.W).
// Normalisation shifts the magnitude left one bit per cycle; a single extra
// cycle rounds and registers the result and flags.
//
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - synchronous active-high reset
//   bus - itof_seq_unit_if.slave (start, int_in, busy, done, result,
//         inexact, z_flag)
//
// Configuration:
//   ITOF_RNE_EN - when defined, ROUND applies round-to-nearest-even;
//                 when undefined, ROUND truncates toward zero.
// ============================================================================
module itof_seq_unit (
    input  logic           clk,
    input  logic           rst,
    itof_seq_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] EXP_START = 8'd158;

    state_t      state;
    state_t      state_next;

    logic        sign_q;
    logic [31:0] mag_q;
    logic [7:0]  exp_q;
    logic [31:0] result_q;
    logic        inexact_q;
    logic        z_flag_q;

    logic        accept;
    logic [31:0] abs_in;

    logic [22:0] mant_raw;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [22:0] mant_rnd;
    logic [7:0]  exp_rnd;
    logic [31:0] result_rnd;

    assign accept = ((state == IDLE) || (state == DONE)) && bus.start;

    // Two's-complement negate wraps -2^31 back onto 0x80000000, which is
    // exactly its magnitude as an unsigned value.
    assign abs_in = bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;

    // Rounding of the normalised magnitude; a carry out of the mantissa
    // leaves mant_sum[22:0] at zero and bumps the exponent.
    always_comb begin
        mant_raw = mag_q[30:8];
        guard    = mag_q[7];
        sticky   = |mag_q[6:0];
`ifdef ITOF_RNE_EN
        round_up = guard & (sticky | mant_raw[0]);
`else
        round_up = 1'b0;
`endif
        mant_sum   = {1'b0, mant_raw} + {23'd0, round_up};
        mant_rnd   = mant_sum[22:0];
        exp_rnd    = mant_sum[23] ? (exp_q + 8'd1) : exp_q;
        result_rnd = {sign_q, exp_rnd, mant_rnd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (abs_in == 32'd0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_next = (abs_in == 32'd0) ? DONE : NORM;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result and flags are only written on entry to DONE (zero operand at
    // accept, or the ROUND cycle), so they hold across busy periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q    <= 1'b0;
            mag_q     <= 32'd0;
            exp_q     <= 8'd0;
            result_q  <= 32'd0;
            inexact_q <= 1'b0;
            z_flag_q  <= 1'b1;
        end else if (accept) begin
            sign_q <= bus.int_in[31];
            mag_q  <= abs_in;
            exp_q  <= EXP_START;
            if (abs_in == 32'd0) begin
                result_q  <= 32'd0;
                inexact_q <= 1'b0;
                z_flag_q  <= 1'b1;
            end
        end else if ((state == NORM) && !mag_q[31]) begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
        end else if (state == ROUND) begin
            result_q  <= result_rnd;
            inexact_q <= guard | sticky;
            z_flag_q  <= (result_rnd == 32'd0);
        end
    end

    assign bus.busy    = (state == NORM) || (state == ROUND);
    assign bus.done    = (state == DONE);
    assign bus.result  = result_q;
    assign bus.inexact = inexact_q;
    assign bus.z_flag  = z_flag_q;

endmodule

// File: tb/tb_itof_seq_unit.sv
// ============================================================================
// tb_itof_seq_unit
// ----------------------------------------------------------------------------
// Directed self-checking bench for itof_seq_unit. Expected results are
// hand-computed IEEE-754 encodings; latencies count the cycle right after
// the accepting edge as 1. Expectations for 0x7FFFFFFF follow ITOF_RNE_EN.
// ============================================================================
module tb_itof_seq_unit;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   lat;
    int   done_seen;

    itof_seq_unit_if bus ();

    itof_seq_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive start for exactly one accepting edge. With now=1 the request is
    // raised immediately (used from inside a DONE cycle for back-to-back).
    task automatic applyStimulus(input logic [31:0] val, input bit now);
        if (!now) @(negedge clk);
        bus.start  = 1'b1;
        bus.int_in = val;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Wait for done, counting cycles from the accepting edge. With glitch=1
    // a stray start (operand 0) is raised while the unit is normalising.
    task automatic waitDone(input bit glitch, output int cycles);
        cycles = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (bus.done) begin
                cycles = c;
                break;
            end
            if (glitch && c == 3) begin
                bus.start  = 1'b1;
                bus.int_in = 32'd0;
            end
            if (glitch && c == 4) begin
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.int_in = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",    {31'd0, bus.busy},    32'd0);
        checkOutput("rst_done",    {31'd0, bus.done},    32'd0);
        checkOutput("rst_result",  bus.result,           32'h0000_0000);
        checkOutput("rst_inexact", {31'd0, bus.inexact}, 32'd0);
        checkOutput("rst_zflag",   {31'd0, bus.z_flag},  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // +1: longest normalisation
        $display("[TB] int_in=0x00000001");
        applyStimulus(32'h0000_0001, 1'b0);
        checkOutput("one_busy", {31'd0, bus.busy}, 32'd1);
        waitDone(1'b0, lat);
        checkOutput("one_latency", lat,                  32'd34);
        checkOutput("one_result",  bus.result,           32'h3F80_0000);
        checkOutput("one_inexact", {31'd0, bus.inexact}, 32'd0);
        checkOutput("one_zflag",   {31'd0, bus.z_flag},  32'd0);
        @(posedge clk);
        #1;
        checkOutput("one_done_pulse", {31'd0, bus.done}, 32'd0);
        checkOutput("one_held",       bus.result,        32'h3F80_0000);

        // -2^31: magnitude must not overflow, shortest path
        $display("[TB] int_in=0x80000000");
        applyStimulus(32'h8000_0000, 1'b0);
        waitDone(1'b0, lat);
        checkOutput("min_latency", lat,                  32'd3);
        checkOutput("min_result",  bus.result,           32'hCF00_0000);
        checkOutput("min_inexact", {31'd0, bus.inexact}, 32'd0);

        // 0x7FFFFFFF: rounds up into the exponent when RNE is enabled
        $display("[TB] int_in=0x7FFFFFFF");
        applyStimulus(32'h7FFF_FFFF, 1'b0);
        waitDone(1'b0, lat);
        checkOutput("max_latency", lat, 32'd4);
`ifdef ITOF_RNE_EN
        checkOutput("max_result", bus.result, 32'h4F00_0000);
`else
        checkOutput("max_result", bus.result, 32'h4EFF_FFFF);
`endif
        checkOutput("max_inexact", {31'd0, bus.inexact}, 32'd1);

        // Tie with even mantissa stays put; stray start mid-conversion ignored
        $display("[TB] int_in=0x01000001 with start during busy");
        applyStimulus(32'h0100_0001, 1'b0);
        waitDone(1'b1, lat);
        checkOutput("tie_latency", lat,                  32'd10);
        checkOutput("tie_result",  bus.result,           32'h4B80_0000);
        checkOutput("tie_inexact", {31'd0, bus.inexact}, 32'd1);

        // Zero operand, then back-to-back -1 from the DONE cycle
        $display("[TB] int_in=0 then back-to-back 0xFFFFFFFF");
        applyStimulus(32'h0000_0000, 1'b0);
        waitDone(1'b0, lat);
        checkOutput("zero_latency", lat,                  32'd1);
        checkOutput("zero_result",  bus.result,           32'h0000_0000);
        checkOutput("zero_zflag",   {31'd0, bus.z_flag},  32'd1);
        checkOutput("zero_inexact", {31'd0, bus.inexact}, 32'd0);
        applyStimulus(32'hFFFF_FFFF, 1'b1);
        checkOutput("b2b_busy", {31'd0, bus.busy}, 32'd1);
        waitDone(1'b0, lat);
        checkOutput("b2b_latency", lat,                  32'd34);
        checkOutput("b2b_result",  bus.result,           32'hBF80_0000);
        checkOutput("b2b_zflag",   {31'd0, bus.z_flag},  32'd0);
        checkOutput("b2b_inexact", {31'd0, bus.inexact}, 32'd0);

        // Reset during normalisation aborts with no done pulse
        $display("[TB] reset abort");
        applyStimulus(32'h0000_0001, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy",    {31'd0, bus.busy},    32'd0);
        checkOutput("abort_done",    {31'd0, bus.done},    32'd0);
        checkOutput("abort_result",  bus.result,           32'h0000_0000);
        checkOutput("abort_inexact", {31'd0, bus.inexact}, 32'd0);
        checkOutput("abort_zflag",   {31'd0, bus.z_flag},  32'd1);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
